// File: rtl/shift_pkg.sv
// Shared constants for the iterative shift unit: operation modes and FSM states.
package shift_pkg;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SLL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One chunk of shifting: moves data by amt (0..STEP) positions in the given mode.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0]       w_dbl;
    logic signed [WIDTH-1:0]  w_sra;

    // Rotation as a right shift of the operand concatenated with itself.
    assign w_dbl = {data, data} >> amt;
    assign w_sra = $signed(data) >>> amt;

    always_comb begin
        result = data;
        case (mode)
            SH_SRL:  result = data >> amt;
            SH_SLL:  result = data << amt;
            SH_SRA:  result = w_sra;
            SH_ROR:  result = w_dbl[WIDTH-1:0];
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shift/rotate unit: accepts one operand, shifts up to STEP bits per
// clock, then holds the result until the consumer takes it.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AMT_W = $clog2(STEP + 1);
    localparam logic [CNT_W:0] STEP_EXT = (CNT_W + 1)'(STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [CNT_W-1:0]   r_rem;
    logic [1:0]         r_mode;
    logic [CNT_W:0]     w_rem_ext;
    logic [CNT_W:0]     w_amt_ext;
    logic [AMT_W-1:0]   w_amt;
    logic [CNT_W-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_accept;

    // Chunk size is min(STEP, remaining); compared one bit wider so STEP==WIDTH fits.
    assign w_rem_ext = {1'b0, r_rem};
    assign w_amt_ext = (w_rem_ext < STEP_EXT) ? w_rem_ext : STEP_EXT;
    assign w_amt     = AMT_W'(w_amt_ext);
    assign w_rem_nxt = r_rem - CNT_W'(w_amt_ext);
    assign w_accept  = (r_state == ST_IDLE) && in_valid;

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data   (r_work),
        .amt    (w_amt),
        .mode   (r_mode),
        .result (w_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (in_cnt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_rem_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work <= '0;
            r_rem  <= '0;
            r_mode <= SH_SRL;
        end else if (w_accept) begin
            r_work <= in_data;
            r_rem  <= in_cnt;
            r_mode <= in_mode;
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_shifted;
            r_rem  <= w_rem_nxt;
        end
    end

    // Partial results in the working register are never exposed.
    assign out_data = out_valid ? r_work : '0;

endmodule
